// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) to one-slave RAM arbiter; registered request, held until ready or watchdog abort.
// Latency: grant seen in cycle N drives m_valid in N+1; masters stall (ready low) until the slave pulses m_ready.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_ready,
    output logic        i_err,
    input  logic        d_valid,
    input  logic [1:0]  d_wstrb,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        m_valid,
    output logic [1:0]  m_wstrb,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_ready
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  wstrb;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    state_t     r_state;
    state_t     w_state_nxt;
    req_t       r_req;
    req_t       w_req_win;
    logic       r_m_valid;
    logic       r_last_d;
    logic [7:0] r_wdog;
    logic       w_any_vld;
    logic       w_grant_d;
    logic       w_timeout;
    logic       w_abort;
    logic       w_i_ready;
    logic       w_d_ready;

    assign w_any_vld = i_valid | d_valid;
    // On a tie the master that did not win the previous grant goes first.
    assign w_grant_d = d_valid & (~i_valid | ~r_last_d);
    assign w_timeout = (TIMEOUT != 0) && (r_wdog == 8'(TIMEOUT - 1));
    assign w_abort   = w_timeout & ~m_ready;
    assign w_req_win = w_grant_d ? '{wstrb: d_wstrb, addr: d_addr, wdata: d_wdata}
                                 : '{wstrb: 2'b00, addr: i_addr, wdata: 16'h0000};

    always_comb begin
        w_state_nxt = r_state;
        w_i_ready   = 1'b0;
        w_d_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_vld) begin
                    w_state_nxt = w_grant_d ? S_BUSY_D : S_BUSY_I;
                end
            end
            S_BUSY_I: begin
                if (m_ready || w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_i_ready   = rst_n;
                end
            end
            S_BUSY_D: begin
                if (m_ready || w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_d_ready   = rst_n;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
            r_req     <= '0;
            r_last_d  <= 1'b0;
            r_wdog    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_wdog <= 8'd0;
                if (w_any_vld) begin
                    r_m_valid <= 1'b1;
                    r_req     <= w_req_win;
                    r_last_d  <= w_grant_d;
                end
            end else if (w_state_nxt == S_IDLE) begin
                // Drop m_valid with the completion so the RAM never sees a stale request.
                r_m_valid <= 1'b0;
                r_wdog    <= 8'd0;
            end else begin
                r_wdog <= r_wdog + 8'd1;
            end
        end
    end

    assign i_ready = w_i_ready;
    assign i_err   = w_i_ready & w_abort;
    assign i_rdata = (w_i_ready & ~w_abort) ? m_rdata : 16'h0000;
    assign d_ready = w_d_ready;
    assign d_err   = w_d_ready & w_abort;
    assign d_rdata = (w_d_ready & ~w_abort) ? m_rdata : 16'h0000;

    assign m_valid = r_m_valid;
    assign m_wstrb = r_req.wstrb;
    assign m_addr  = r_req.addr;
    assign m_wdata = r_req.wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 1-wait RAM model with hang control, scoreboard of expected completions.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready, i_err;
    logic [15:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_err;
    logic [1:0]  d_wstrb;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        m_valid, m_ready;
    logic [1:0]  m_wstrb;
    logic [15:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
        .d_valid(d_valid), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    // RAM model: ready one cycle after m_valid is seen unless hung; junk on rdata when idle.
    logic [15:0] mem [0:255];
    logic        s_rdy = 1'b0;
    logic        slv_hang, bd_we;
    logic [15:0] bd_addr, bd_dat;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr[8:1]] <= bd_dat;
        s_rdy <= m_valid && !s_rdy && !slv_hang;
        if (s_rdy && m_valid && m_wstrb == 2'b01) begin
            if (m_addr[0]) mem[m_addr[8:1]][15:8] <= m_wdata[7:0];
            else           mem[m_addr[8:1]][7:0]  <= m_wdata[7:0];
        end else if (s_rdy && m_valid && m_wstrb[1]) begin
            mem[m_addr[8:1]] <= m_wdata;
        end
    end
    assign m_ready = s_rdy;
    assign m_rdata = !s_rdy ? 16'hDEAD : (m_wstrb == 2'b00) ? mem[m_addr[8:1]] : 16'h0000;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [15:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input bit is_d, input bit err, input logic [15:0] rdata);
        exp_q.push_back('{is_d: is_d, err: err, rdata: rdata});
    endtask

    task automatic backdoor(input logic [15:0] a, input logic [15:0] v);
        bd_addr = a; bd_dat = v; bd_we = 1'b1;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_valid = 1'b0; d_valid = 1'b0; slv_hang = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++;
        if ({m_valid, m_wstrb, m_addr, m_wdata} !== 35'h0) begin
            n_fail++; $display("FAIL reset_mport: got %h expected 0", {m_valid, m_wstrb, m_addr, m_wdata});
        end
        n_checks++;
        if ({i_ready, i_err, d_ready, d_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", {i_ready, i_err, d_ready, d_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lone_fetch();
        backdoor(16'h0010, 16'hBEEF);
        i_addr = 16'h0010; i_valid = 1'b1;
        push_exp(1'b0, 1'b0, 16'hBEEF);
        step();
        n_checks++;
        if ({m_valid, m_wstrb, m_addr, m_wdata} !== {1'b1, 2'b00, 16'h0010, 16'h0000}) begin
            n_fail++; $display("FAIL lone_mreq: got %h expected %h", {m_valid, m_wstrb, m_addr, m_wdata},
                               {1'b1, 2'b00, 16'h0010, 16'h0000});
        end
        n_checks++;
        if (i_ready !== 1'b0) begin n_fail++; $display("FAIL lone_early_ready: got %b expected 0", i_ready); end
        step();
        n_checks++;
        if ({i_ready, d_ready} !== 2'b10) begin
            n_fail++; $display("FAIL lone_ready: got %b expected 10", {i_ready, d_ready});
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({i_err, i_rdata} !== {e.err, e.rdata}) begin
            n_fail++; $display("FAIL lone_rdata: got %h expected %h", {i_err, i_rdata}, {e.err, e.rdata});
        end
        i_valid = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lone_mvalid_after: got %b expected 0", m_valid); end
    endtask

    task automatic test_tie();
        int nd = 0;
        bit prev_rdy = 1'b0;
        do_reset();
        i_addr = 16'h0004; i_valid = 1'b1;
        d_addr = 16'h0004; d_wstrb = 2'b11; d_wdata = 16'h1234; d_valid = 1'b1;
        push_exp(1'b1, 1'b0, 16'h0000);
        push_exp(1'b0, 1'b0, 16'h1234);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            step();
            n_checks++;
            if (prev_rdy && m_valid !== 1'b0) begin n_fail++; $display("FAIL tie_mvalid_after: got %b expected 0", m_valid); end
            n_checks++;
            if (i_ready && d_ready) begin n_fail++; $display("FAIL tie_both_ready: got 11 expected one-hot"); end
            if (i_ready || d_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({d_ready, d_ready ? d_err : i_err, d_ready ? d_rdata : i_rdata} !== {e.is_d, e.err, e.rdata}) begin
                    n_fail++; $display("FAIL tie_order: got %h expected %h",
                        {d_ready, d_ready ? d_err : i_err, d_ready ? d_rdata : i_rdata}, {e.is_d, e.err, e.rdata});
                end
                if (i_ready) i_valid = 1'b0;
                if (d_ready) begin
                    nd++;
                    // D re-requests immediately while I still waits: second tie, I must win.
                    if (nd == 1) begin d_wstrb = 2'b00; push_exp(1'b1, 1'b0, 16'h1234); end
                    else d_valid = 1'b0;
                end
            end
            prev_rdy = i_ready || d_ready;
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL tie_timeout: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
        i_valid = 1'b0; d_valid = 1'b0;
        step();
    endtask

    task automatic test_odd_byte();
        backdoor(16'h0002, 16'h5566);
        slv_hang = 1'b1;
        d_addr = 16'h0003; d_wstrb = 2'b01; d_wdata = 16'h00AA; d_valid = 1'b1;
        push_exp(1'b1, 1'b0, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({m_valid, m_wstrb, m_addr, m_wdata, d_ready} !== {1'b1, 2'b01, 16'h0003, 16'h00AA, 1'b0}) begin
                n_fail++; $display("FAIL odd_hold: got %h expected %h", {m_valid, m_wstrb, m_addr, m_wdata, d_ready},
                                   {1'b1, 2'b01, 16'h0003, 16'h00AA, 1'b0});
            end
        end
        slv_hang = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, e.err, e.rdata}) begin
            n_fail++; $display("FAIL odd_done: got %h expected %h", {d_ready, d_err, d_rdata}, {1'b1, e.err, e.rdata});
        end
        d_valid = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL odd_mvalid_after: got %b expected 0", m_valid); end
        i_addr = 16'h0002; i_valid = 1'b1;
        push_exp(1'b0, 1'b0, 16'hAA66);
        step(); step();
        e = exp_q.pop_front();
        n_checks++;
        if ({i_ready, i_err, i_rdata} !== {1'b1, e.err, e.rdata}) begin
            n_fail++; $display("FAIL odd_readback: got %h expected %h", {i_ready, i_err, i_rdata}, {1'b1, e.err, e.rdata});
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int mv_cnt = 0;
        bit seen = 1'b0;
        slv_hang = 1'b1;
        d_addr = 16'h0004; d_wstrb = 2'b00; d_valid = 1'b1;
        push_exp(1'b1, 1'b1, 16'h0000);
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (m_valid) mv_cnt++;
            n_checks++;
            if (i_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_i_ready: got %b expected 0", i_ready); end
            if (d_ready) begin
                seen = 1'b1;
                n_checks++;
                if (mv_cnt != 16) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 16", mv_cnt); end
                e = exp_q.pop_front();
                n_checks++;
                if ({d_err, d_rdata} !== {e.err, e.rdata}) begin
                    n_fail++; $display("FAIL tmo_err: got %h expected %h", {d_err, d_rdata}, {e.err, e.rdata});
                end
                d_valid = 1'b0;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL tmo_never: got no d_ready expected abort"); exp_q.delete(); end
        slv_hang = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_mvalid_after: got %b expected 0", m_valid); end
        d_valid = 1'b1;
        push_exp(1'b1, 1'b0, 16'h1234);
        step(); step();
        e = exp_q.pop_front();
        n_checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, e.err, e.rdata}) begin
            n_fail++; $display("FAIL tmo_recover: got %h expected %h", {d_ready, d_err, d_rdata}, {1'b1, e.err, e.rdata});
        end
        d_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_busy();
        slv_hang = 1'b1;
        d_addr = 16'h0004; d_wstrb = 2'b00; d_valid = 1'b1;
        step();
        n_checks++;
        if ({m_valid, d_ready} !== 2'b10) begin n_fail++; $display("FAIL rstb_busy: got %b expected 10", {m_valid, d_ready}); end
        slv_hang = 1'b0;
        // Slave acks in the very cycle reset is asserted: the ack must be swallowed.
        @(posedge clk); #1;
        rst_n = 1'b0; d_valid = 1'b0;
        #1;
        n_checks++;
        if ({d_ready, d_err} !== 2'b00) begin n_fail++; $display("FAIL rstb_ready_in_reset: got %b expected 00", {d_ready, d_err}); end
        step();
        step();
        n_checks++;
        if ({m_valid, d_ready} !== 2'b00) begin n_fail++; $display("FAIL rstb_after: got %b expected 00", {m_valid, d_ready}); end
        rst_n = 1'b1;
        step();
        d_valid = 1'b1;
        push_exp(1'b1, 1'b0, 16'h1234);
        step(); step();
        e = exp_q.pop_front();
        n_checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, e.err, e.rdata}) begin
            n_fail++; $display("FAIL rstb_recover: got %h expected %h", {d_ready, d_err, d_rdata}, {1'b1, e.err, e.rdata});
        end
        d_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit prev_rdy = 1'b0;
        do_reset();
        i_addr = 16'h0010; d_addr = 16'h0004; d_wstrb = 2'b00;
        i_valid = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) push_exp(1'b1, 1'b0, 16'h1234);
            else            push_exp(1'b0, 1'b0, 16'hBEEF);
        end
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            step();
            n_checks++;
            if (prev_rdy && m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_mvalid_after: got %b expected 0", m_valid); end
            n_checks++;
            if (i_ready && d_ready) begin n_fail++; $display("FAIL b2b_both_ready: got 11 expected one-hot"); end
            n_checks++;
            if ((!i_ready && {i_err, i_rdata} !== 17'h0) || (!d_ready && {d_err, d_rdata} !== 17'h0)) begin
                n_fail++; $display("FAIL b2b_idle_outputs: got i=%h d=%h expected 0", {i_err, i_rdata}, {d_err, d_rdata});
            end
            if (i_ready || d_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({d_ready, d_ready ? d_err : i_err, d_ready ? d_rdata : i_rdata} !== {e.is_d, e.err, e.rdata}) begin
                    n_fail++; $display("FAIL b2b_order: got %h expected %h",
                        {d_ready, d_ready ? d_err : i_err, d_ready ? d_rdata : i_rdata}, {e.is_d, e.err, e.rdata});
                end
                if (exp_q.size() == 0) begin i_valid = 1'b0; d_valid = 1'b0; end
            end
            prev_rdy = i_ready || d_ready;
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
        i_valid = 1'b0; d_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; slv_hang = 1'b0; bd_we = 1'b0; bd_addr = 16'h0; bd_dat = 16'h0;
        i_valid = 1'b0; i_addr = 16'h0;
        d_valid = 1'b0; d_wstrb = 2'b00; d_addr = 16'h0; d_wdata = 16'h0;
        test_reset();
        test_lone_fetch();
        test_tie();
        test_odd_byte();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
